// File: rtl/coproc_pkg.sv
// coproc_pkg: shared X-IF widths, arbiter state encoding
// and the latched memory request bundle for coproc_mem_arbiter.
package coproc_pkg;

  localparam int XIF_ID_W   = 4;
  localparam int XIF_DATA_W = 32;
  localparam int XIF_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RES = 2'd2,
    RESP     = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [XIF_ID_W-1:0]   id;
    logic [XIF_DATA_W-1:0] addr;
    logic                  we;
    logic [XIF_BE_W-1:0]   be;
    logic [XIF_DATA_W-1:0] wdata;
  } mem_req_t;

  // Round-robin successor of idx among n slots.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/coproc_rr_pick.sv
// coproc_rr_pick: combinational round-robin picker.
// Ports: valid (requests), ptr (priority start) -> grant (one-hot), idx, any.
module coproc_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/coproc_mem_arbiter.sv
// coproc_mem_arbiter: shares the coprocessor X-IF mem/mem_result channel
// between NUM_REQ requesters, round-robin, one transaction outstanding.
// Ports: clk_i, rst_ni (async, active-low); req_* per-requester request
// (valid/ready pulse, id/addr/we/be/wdata); resp_* one-cycle response to
// the owner; mem_* X-IF request; mem_result_* X-IF result;
// protocol_err_o sticky flag for unexpected or mismatched results.
// ID_WIDTH/DATA_WIDTH must equal the coproc_pkg X-IF widths.
// Optional: define COPROC_MEM_ARB_TIMEOUT_EN for a WAIT_RES watchdog
// of TIMEOUT_CYCLES that answers with resp_err_o=1, rdata 0.
module coproc_mem_arbiter
  import coproc_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ID_WIDTH       = XIF_ID_W,
  parameter int DATA_WIDTH     = XIF_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ID_WIDTH-1:0]   req_id_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*4-1:0]          req_be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  output logic [DATA_WIDTH-1:0]         resp_rdata_o,
  output logic                          resp_err_o,
  output logic                          mem_valid_o,
  input  logic                          mem_ready_i,
  output logic [ID_WIDTH-1:0]           mem_id_o,
  output logic [DATA_WIDTH-1:0]         mem_addr_o,
  output logic                          mem_we_o,
  output logic [3:0]                    mem_be_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic                          mem_result_valid_i,
  input  logic [ID_WIDTH-1:0]           mem_result_id_i,
  input  logic [DATA_WIDTH-1:0]         mem_result_rdata_i,
  input  logic                          mem_result_err_i,
  output logic                          protocol_err_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         owner_q;
  mem_req_t              req_q;
  mem_req_t              sel_req;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  perr_q;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  grant_en;
  logic                  res_hit;
  logic                  res_bad;
  logic                  tmo_hit;

  coproc_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .valid (req_valid_i),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_req.id    = req_id_i[pick_idx*ID_WIDTH +: ID_WIDTH];
    sel_req.addr  = req_addr_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
    sel_req.we    = req_we_i[pick_idx];
    sel_req.be    = req_be_i[pick_idx*4 +: 4];
    sel_req.wdata = req_wdata_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  assign grant_en = (state_q == IDLE) && pick_any;

  // Only a beat in WAIT_RES carrying our id completes the transaction;
  // anything else on the result channel is a protocol violation.
  assign res_hit = (state_q == WAIT_RES) && mem_result_valid_i &&
                   (mem_result_id_i == req_q.id);
  assign res_bad = mem_result_valid_i && !res_hit;

`ifdef COPROC_MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q != WAIT_RES) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A matching result in the same cycle takes precedence.
  assign tmo_hit = (state_q == WAIT_RES) && !res_hit &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (pick_any) state_d = REQ;
      REQ:      if (mem_ready_i) state_d = WAIT_RES;
      WAIT_RES: if (res_hit || tmo_hit) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      owner_q <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (grant_en) begin
        owner_q <= pick_idx;
        ptr_q   <= IW'(rr_next(int'(pick_idx), NUM_REQ));
        req_q   <= sel_req;
      end
      if (res_hit) begin
        rdata_q <= mem_result_rdata_i;
        err_q   <= mem_result_err_i;
      end else if (tmo_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      if (res_bad) perr_q <= 1'b1;
    end
  end

  always_comb begin
    req_ready_o  = '0;
    mem_valid_o  = 1'b0;
    mem_id_o     = '0;
    mem_addr_o   = '0;
    mem_we_o     = 1'b0;
    mem_be_o     = '0;
    mem_wdata_o  = '0;
    resp_valid_o = '0;
    resp_rdata_o = '0;
    resp_err_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Keep the grant quiet while reset is held.
        req_ready_o = pick_grant & {NUM_REQ{rst_ni}};
      end
      REQ: begin
        mem_valid_o = 1'b1;
        mem_id_o    = req_q.id;
        mem_addr_o  = req_q.addr;
        mem_we_o    = req_q.we;
        mem_be_o    = req_q.be;
        mem_wdata_o = req_q.wdata;
      end
      RESP: begin
        resp_valid_o[owner_q] = 1'b1;
        resp_rdata_o          = rdata_q;
        resp_err_o            = err_q;
      end
      default: ;
    endcase
  end

  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_coproc_mem_arbiter.sv
// tb_coproc_mem_arbiter: randomized + directed bench with scoreboard
// for coproc_mem_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
module tb_coproc_mem_arbiter;

  localparam int N   = 2;
  localparam int IDW = 4;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [N*IDW-1:0]  req_id_i;
  logic [N*DW-1:0]   req_addr_i;
  logic [N-1:0]      req_we_i;
  logic [N*4-1:0]    req_be_i;
  logic [N*DW-1:0]   req_wdata_i;
  logic [N-1:0]      resp_valid_o;
  logic [DW-1:0]     resp_rdata_o;
  logic              resp_err_o;
  logic              mem_valid_o;
  logic              mem_ready_i;
  logic [IDW-1:0]    mem_id_o;
  logic [DW-1:0]     mem_addr_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [DW-1:0]     mem_wdata_o;
  logic              mem_result_valid_i;
  logic [IDW-1:0]    mem_result_id_i;
  logic [DW-1:0]     mem_result_rdata_i;
  logic              mem_result_err_i;
  logic              protocol_err_o;

  always #5 clk_i = ~clk_i;

  coproc_mem_arbiter #(
    .NUM_REQ        (N),
    .ID_WIDTH       (IDW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_id_i           (req_id_i),
    .req_addr_i         (req_addr_i),
    .req_we_i           (req_we_i),
    .req_be_i           (req_be_i),
    .req_wdata_i        (req_wdata_i),
    .resp_valid_o       (resp_valid_o),
    .resp_rdata_o       (resp_rdata_o),
    .resp_err_o         (resp_err_o),
    .mem_valid_o        (mem_valid_o),
    .mem_ready_i        (mem_ready_i),
    .mem_id_o           (mem_id_o),
    .mem_addr_o         (mem_addr_o),
    .mem_we_o           (mem_we_o),
    .mem_be_o           (mem_be_o),
    .mem_wdata_o        (mem_wdata_o),
    .mem_result_valid_i (mem_result_valid_i),
    .mem_result_id_i    (mem_result_id_i),
    .mem_result_rdata_i (mem_result_rdata_i),
    .mem_result_err_i   (mem_result_err_i),
    .protocol_err_o     (protocol_err_o)
  );

  typedef struct {
    int            owner;
    logic [IDW-1:0] id;
    logic [DW-1:0] addr;
    logic          we;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
  } tx_t;

  typedef struct {
    int            owner;
    logic [DW-1:0] rdata;
    logic          err;
  } rs_t;

  int  errors = 0;
  int  checks = 0;

  tx_t pend[N][$];
  tx_t txq[$];
  rs_t rsq[$];
  tx_t cur;
  bit  granted[N];
  int  grant_log[$];

  // Transaction-level model: phase 0 free, 1 granted, 2 issued,
  // 3 result accepted (response due next cycle).
  int  phase = 0;
  int  model_ptr = 0;
  bit  exp_perr = 0;
  int  wcnt = 0;

  bit             pv_valid = 0;
  bit             pv_ready = 0;
  logic [IDW-1:0] pv_id;
  logic [DW-1:0]  pv_addr;
  logic [DW-1:0]  pv_wdata;
  logic           pv_we;
  logic [3:0]     pv_be;

  int          k_stall = 0;
  int          k_lat = 0;
  bit          k_bad = 0;
  bit          k_noresp = 0;
  bit          k_rand = 0;
  bit          k_fix = 0;
  logic [DW-1:0] k_rdata = '0;
  logic        k_err = 0;
  int          rs_st = 0;
  int          rs_cnt = 0;
  bit          bad_left = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_model();
    phase     = 0;
    model_ptr = 0;
    exp_perr  = 0;
    wcnt      = 0;
    pv_valid  = 0;
    txq.delete();
    rsq.delete();
    for (int i = 0; i < N; i++) begin
      pend[i].delete();
      granted[i] = 0;
    end
  endtask

  // Requesters: hold payload until the grant seen by the monitor.
  always @(posedge clk_i) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (granted[i]) begin
        granted[i] = 0;
        if (pend[i].size() > 0) void'(pend[i].pop_front());
      end
      if (rst_ni && pend[i].size() > 0) begin
        req_valid_i[i]            = 1'b1;
        req_id_i[i*IDW +: IDW]    = pend[i][0].id;
        req_addr_i[i*DW +: DW]    = pend[i][0].addr;
        req_we_i[i]               = pend[i][0].we;
        req_be_i[i*4 +: 4]        = pend[i][0].be;
        req_wdata_i[i*DW +: DW]   = pend[i][0].wdata;
      end else begin
        req_valid_i[i] = 1'b0;
      end
    end
  end

  // Memory side responder.
  always @(posedge clk_i) begin
    logic [DW-1:0] rd;
    #1;
    mem_result_valid_i = 1'b0;
    mem_result_id_i    = '0;
    mem_result_rdata_i = '0;
    mem_result_err_i   = 1'b0;
    if (!rst_ni) begin
      rs_st       = 0;
      mem_ready_i = 1'b0;
    end else begin
      case (rs_st)
        0: begin
          mem_ready_i = 1'b0;
          if (mem_valid_o) begin
            if (k_rand) begin
              k_stall = $urandom_range(0, 3);
              k_lat   = $urandom_range(0, 3);
              k_err   = ($urandom_range(0, 3) == 0);
            end
            if (k_stall == 0) begin
              mem_ready_i = 1'b1;
              rs_st       = 2;
            end else begin
              rs_cnt = k_stall;
              rs_st  = 1;
            end
          end
        end
        1: begin
          rs_cnt--;
          if (rs_cnt == 0) begin
            mem_ready_i = 1'b1;
            rs_st       = 2;
          end
        end
        2: begin
          mem_ready_i = 1'b0;
          rs_cnt      = k_lat;
          bad_left    = k_bad;
          rs_st       = k_noresp ? 0 : 3;
        end
        default: begin
          if (rs_cnt > 0) begin
            rs_cnt--;
          end else if (bad_left) begin
            bad_left           = 0;
            mem_result_valid_i = 1'b1;
            mem_result_id_i    = cur.id + 4'd2;
            mem_result_rdata_i = 32'h0BAD_0BAD;
          end else begin
            rd                 = k_fix ? k_rdata : DW'($urandom);
            mem_result_valid_i = 1'b1;
            mem_result_id_i    = cur.id;
            mem_result_rdata_i = rd;
            mem_result_err_i   = k_err;
            rsq.push_back('{cur.owner, rd, k_err});
            rs_st = 0;
          end
        end
      endcase
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk_i) begin
    int ph;
    int w;
    int j;
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_r;
    bit legal;
    tx_t t;
    rs_t r;
    if (!rst_ni) begin
      pv_valid = 0;
    end else begin
      ph = phase;
      chk("protocol_err", protocol_err_o, exp_perr);

      w = -1;
      exp_g = '0;
      if (ph == 0) begin
        for (int k = 0; k < N; k++) begin
          j = (model_ptr + k) % N;
          if (w < 0 && req_valid_i[j] && pend[j].size() > 0) w = j;
        end
      end
      if (w >= 0) exp_g[w] = 1'b1;
      chk("grant", req_ready_o, exp_g);
      for (int i = 0; i < N; i++)
        if (req_ready_o[i]) granted[i] = 1;
      if (w >= 0) begin
        t = pend[w][0];
        t.owner = w;
        txq.push_back(t);
        grant_log.push_back(w);
        model_ptr = (w + 1) % N;
        phase = 1;
      end

      chk("mem_valid", mem_valid_o, ph == 1);
      if (pv_valid && !pv_ready) begin
        chk("hold_ctl", {mem_valid_o, mem_id_o, mem_we_o, mem_be_o},
            {1'b1, pv_id, pv_we, pv_be});
        chk("hold_addr", mem_addr_o, pv_addr);
        chk("hold_wdata", mem_wdata_o, pv_wdata);
      end
      if (ph == 1 && mem_valid_o && mem_ready_i) begin
        if (txq.size() > 0) begin
          cur = txq.pop_front();
          chk("mem_id", mem_id_o, cur.id);
          chk("mem_addr", mem_addr_o, cur.addr);
          chk("mem_we_be", {mem_we_o, mem_be_o}, {cur.we, cur.be});
          chk("mem_wdata", mem_wdata_o, cur.wdata);
        end
        phase = 2;
        wcnt  = 0;
      end

      legal = mem_result_valid_i && ph == 2 && mem_result_id_i == cur.id;
      if (mem_result_valid_i && !legal) exp_perr = 1;
      if (legal) begin
        phase = 3;
      end
`ifdef COPROC_MEM_ARB_TIMEOUT_EN
      else if (ph == 2) begin
        wcnt++;
        if (wcnt == TMO) begin
          phase = 3;
          rsq.push_back('{cur.owner, '0, 1'b1});
        end
      end
`endif

      exp_r = '0;
      if (ph == 3) exp_r[cur.owner] = 1'b1;
      chk("resp_valid", resp_valid_o, exp_r);
      if (ph == 3) begin
        if (rsq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_queue: got response, expected none queued");
        end else begin
          r = rsq.pop_front();
          chk("resp_rdata", resp_rdata_o, r.rdata);
          chk("resp_err", resp_err_o, r.err);
        end
        phase = 0;
      end

      pv_valid = mem_valid_o;
      pv_ready = mem_ready_i;
      pv_id    = mem_id_o;
      pv_addr  = mem_addr_o;
      pv_wdata = mem_wdata_o;
      pv_we    = mem_we_o;
      pv_be    = mem_be_o;
    end
  end

  task automatic push_tx(input int i, input logic [IDW-1:0] id,
                         input logic [DW-1:0] addr, input logic we,
                         input logic [3:0] be, input logic [DW-1:0] wd);
    pend[i].push_back('{i, id, addr, we, be, wd});
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (n < budget && !(pend[0].size() == 0 && pend[1].size() == 0 &&
                           phase == 0 && rs_st == 0)) begin
      @(posedge clk_i);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: drain timeout after %0d cycles, phase %0d", nm, n,
               phase);
    end
    repeat (2) @(posedge clk_i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ni             = 1'b0;
    req_valid_i        = '0;
    req_id_i           = '0;
    req_addr_i         = '0;
    req_we_i           = '0;
    req_be_i           = '0;
    req_wdata_i        = '0;
    mem_ready_i        = 1'b0;
    mem_result_valid_i = 1'b0;
    mem_result_id_i    = '0;
    mem_result_rdata_i = '0;
    mem_result_err_i   = 1'b0;
    reset_model();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_perr", protocol_err_o, 0);
    @(posedge clk_i);
    #2 rst_ni = 1'b1;

    // Both requesters busy: strict alternation from pointer 0.
    grant_log.delete();
    @(posedge clk_i);
    push_tx(0, 4'd1, 32'h0000_0010, 1'b0, 4'hF, 32'h0);
    push_tx(0, 4'd2, 32'h0000_0020, 1'b1, 4'h3, 32'h1111_2222);
    push_tx(1, 4'd4, 32'h0000_0030, 1'b0, 4'hF, 32'h0);
    push_tx(1, 4'd6, 32'h0000_0040, 1'b1, 4'hC, 32'h3333_4444);
    drain("order", 200);
    chk("order_n", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("order0", grant_log[0], 0);
      chk("order1", grant_log[1], 1);
      chk("order2", grant_log[2], 0);
      chk("order3", grant_log[3], 1);
    end

    // Single read, ready one cycle late, fixed read data.
    k_stall = 1;
    k_fix   = 1;
    k_rdata = 32'hDEAD_BEEF;
    k_err   = 0;
    @(posedge clk_i);
    push_tx(0, 4'd3, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
    drain("single", 100);
    k_fix = 0;

    // Back-pressure: request must stay stable for 5 stalled cycles.
    k_stall = 5;
    @(posedge clk_i);
    push_tx(1, 4'd9, 32'h0000_2040, 1'b1, 4'h5, 32'hCAFE_F00D);
    drain("stall", 100);
    k_stall = 0;

    // Wrong id beat first, then the correct one.
    k_bad = 1;
    @(posedge clk_i);
    push_tx(0, 4'd3, 32'h0000_0300, 1'b0, 4'hF, 32'h0);
    drain("bad_id", 100);
    k_bad = 0;
    chk("perr_sticky", protocol_err_o, 1);

    // Random traffic.
    k_rand = 1;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk_i);
      push_tx($urandom_range(0, N - 1), IDW'($urandom), DW'($urandom),
              1'($urandom), 4'($urandom), DW'($urandom));
      repeat ($urandom_range(0, 6)) @(posedge clk_i);
    end
    drain("random", 3000);
    k_rand  = 0;
    k_stall = 0;
    k_lat   = 0;
    k_err   = 0;

    // Reset while waiting for a result.
    k_noresp = 1;
    @(posedge clk_i);
    push_tx(0, 4'd7, 32'h0000_0700, 1'b0, 4'hF, 32'h0);
    for (int n = 0; n < 50 && phase != 2; n++) @(posedge clk_i);
    chk("reached_wait", phase, 2);
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni      = 1'b0;
    req_valid_i = '0;
    reset_model();
    #1;
    chk("arst_ready", req_ready_o, 0);
    chk("arst_mem_valid", mem_valid_o, 0);
    chk("arst_mem_addr", mem_addr_o, 0);
    chk("arst_resp_valid", resp_valid_o, 0);
    chk("arst_perr", protocol_err_o, 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_i);
      chk("arst_no_resp", resp_valid_o, 0);
    end
    k_noresp = 0;
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    grant_log.delete();
    @(posedge clk_i);
    push_tx(1, 4'd8, 32'h0000_0800, 1'b0, 4'hF, 32'h0);
    push_tx(0, 4'd5, 32'h0000_0500, 1'b0, 4'hF, 32'h0);
    drain("post_reset", 200);
    chk("post_reset_n", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("post_reset_first", grant_log[0], 0);

`ifdef COPROC_MEM_ARB_TIMEOUT_EN
    // No result at all: watchdog answers with an error.
    k_noresp = 1;
    @(posedge clk_i);
    push_tx(1, 4'd2, 32'h0000_0900, 1'b0, 4'hF, 32'h0);
    drain("timeout", 200);
    k_noresp = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
